laplace_scheduler: RTL and testbench
====================================

// Module: laplace_scheduler
// PURPOSE
//   Sequences the combinational Laplace kernel (inputs b,d,e,f,h; output s[8:0]) across a
//   ROWS x COLS 8-bit image held in a row-major source memory.
//   For every interior pixel it fetches the 4-neighbour cross, presents it to the kernel and
//   writes s[7:0] to a destination memory in raster order. Output image is (ROWS-2) x (COLS-2).
//   Sits between the image RAM, the laplace kernel instance and the result RAM; the top level
//   starts it with a start/busy/done handshake.
// PARAMETERS
//   ROWS    512  image height in pixels (>=3)
//   COLS    512  image width in pixels (>=3)
//   ADDR_W  18   address width for source and destination memories (2**ADDR_W >= ROWS*COLS)
// PORTS
//   clk        in   1       single clock, all logic on rising edge
//   rst        in   1       synchronous, active-high reset
//   start      in   1       begin one full-image pass (sampled only in IDLE)
//   busy       out  1       high from the cycle after start is accepted until done
//   done       out  1       one-cycle pulse after the final write
//   src_rd     out  1       source read strobe
//   src_addr   out  ADDR_W  source pixel address
//   src_data   in   8       source data, valid exactly 1 cycle after src_rd
//   k_b,k_d,k_e,k_f,k_h out 8  registered neighbours to kernel (up, left, centre, right, down)
//   k_s        in   9       kernel result
//   dst_we     out  1       destination write strobe
//   dst_addr   out  ADDR_W  destination pixel index
//   dst_data   out  8       k_s[7:0] (low byte, no saturation)
//   dst_ready  in   1       destination accepts write when high
// BEHAVIOUR
//   Reset: state IDLE; busy, done, src_rd, dst_we = 0; src_addr, dst_addr, dst_data,
//     k_b..k_h = 0; row/col counters = 0. Reset mid-pass aborts immediately, no further writes.
//   Counters r in 0..ROWS-3, c in 0..COLS-3; base = r*COLS + c (kept incrementally, no multiplier).
//   FSM: IDLE -> F0 -> F1 -> F2 -> F3 -> F4 -> LAST -> WR -> (F0 | DONE) -> IDLE.
//   IDLE: start=1 -> F0 next cycle, busy=1. start while busy is ignored.
//   F0..F4: src_rd=1, src_addr = base+1, base+COLS, base+COLS+1, base+COLS+2, base+2*COLS+1.
//   Capture: data returned in cycle after Fi is stored to k_b,k_d,k_e,k_f,k_h in order
//     (capture of Fi happens in F(i+1) or LAST).
//   LAST: src_rd=0; k_h captured; kernel inputs are now complete and stable.
//   WR: dst_we=1, dst_addr=r*(COLS-2)+c (running counter), dst_data=k_s[7:0].
//     Held with all outputs stable while dst_ready=0. On dst_ready=1 the write is complete:
//     c++; at c=COLS-3 c wraps to 0 and r++.
//     Base advances by +1, or by +3 on column wrap.
//     After the last pixel (r=ROWS-3, c=COLS-3) go to DONE, else F0.
//   DONE: done=1, busy=0 for one cycle, counters cleared -> IDLE.
//   Throughput: 7 cycles/pixel with no stall. Start-accept to done = 1 + 7*(ROWS-2)*(COLS-2)
//     + stall cycles.
//   Kernel is combinational; dst_data must be sampled from k_s in WR only.
// TESTING (ROWS=4, COLS=5 unless noted; 6 output pixels; bench uses a memory model and a
//   behavioural kernel)
//   1. Assert rst 2 cycles -> all outputs 0, busy=0.
//      start during reset -> ignored, no src_rd.
//   2. Pixel (0,0) -> src_addr sequence 1,5,6,7,11; pixel index 3 (r=1,c=0) -> 6,10,11,12,16.
//   3. Constant image of 8'd10, real kernel -> six writes, dst_addr 0..5, dst_data 0;
//      done pulse 43 cycles after start-accept; busy low in the same cycle as done.
//   4. Kernel stub forces k_s=9'h1A5 -> every dst_data=8'hA5 (truncation, not saturation).
//   5. dst_ready low for 3 cycles at first WR -> dst_we/addr/data held stable; done delayed
//      to cycle 46.
//   6. rst pulse while in F2 of pixel 4 -> next cycle IDLE, all outputs 0;
//      new start -> first src_addr=1, dst_addr restarts at 0.

Source files
------------

// File: rtl/laplace_scheduler.sv
// laplace_scheduler: walks the interior pixels of a ROWS x COLS row-major
// image, fetches the 4-neighbour cross for each, feeds the external
// combinational Laplace kernel and writes its low byte to the result RAM.
// Seven cycles per pixel (five reads, one capture, one write) plus stalls.
module laplace_scheduler #(
  parameter int ROWS   = 512,
  parameter int COLS   = 512,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_data,
  output logic [7:0]        k_b,
  output logic [7:0]        k_d,
  output logic [7:0]        k_e,
  output logic [7:0]        k_f,
  output logic [7:0]        k_h,
  input  logic [8:0]        k_s,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [7:0]        dst_data,
  input  logic              dst_ready
);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3, S_F4, S_LAST, S_WR, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] OFF_C   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] OFF_C1  = ADDR_W'(COLS + 1);
  localparam logic [ADDR_W-1:0] OFF_C2  = ADDR_W'(COLS + 2);
  localparam logic [ADDR_W-1:0] OFF_2C1 = ADDR_W'(2 * COLS + 1);
  localparam logic [ADDR_W-1:0] LAST_R  = ADDR_W'(ROWS - 3);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(COLS - 3);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_row, r_col;   // output-pixel coordinates
  logic [ADDR_W-1:0] r_base;         // r*COLS + c, tracked incrementally
  logic [ADDR_W-1:0] r_dst_idx;      // r*(COLS-2) + c, running
  logic              w_last_col, w_last_pix, w_wr_done;

  // The kernel result is 9 bits; only the low byte is written (truncation).
  logic w_unused_ks8;
  assign w_unused_ks8 = k_s[8];

  assign w_last_col = (r_col == LAST_C);
  assign w_last_pix = w_last_col && (r_row == LAST_R);
  assign w_wr_done  = (r_state == S_WR) && dst_ready;

  // State register; synchronous reset aborts a pass at once.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: fixed fetch sequence, WR holds until the write is accepted.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_F0;
      S_F0:    w_next = S_F1;
      S_F1:    w_next = S_F2;
      S_F2:    w_next = S_F3;
      S_F3:    w_next = S_F4;
      S_F4:    w_next = S_LAST;
      S_LAST:  w_next = S_WR;
      S_WR:    if (dst_ready) w_next = w_last_pix ? S_DONE : S_F0;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; idle values are all zero.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    src_rd   = 1'b0;
    src_addr = '0;
    dst_we   = 1'b0;
    dst_addr = '0;
    dst_data = '0;
    case (r_state)
      S_F0:   begin busy = 1'b1; src_rd = 1'b1; src_addr = r_base + ADDR_W'(1); end
      S_F1:   begin busy = 1'b1; src_rd = 1'b1; src_addr = r_base + OFF_C;      end
      S_F2:   begin busy = 1'b1; src_rd = 1'b1; src_addr = r_base + OFF_C1;     end
      S_F3:   begin busy = 1'b1; src_rd = 1'b1; src_addr = r_base + OFF_C2;     end
      S_F4:   begin busy = 1'b1; src_rd = 1'b1; src_addr = r_base + OFF_2C1;    end
      S_LAST: busy = 1'b1;
      S_WR:   begin
        busy     = 1'b1;
        dst_we   = 1'b1;
        dst_addr = r_dst_idx;
        dst_data = k_s[7:0];
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Neighbour capture (one cycle behind each read) and raster counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_b       <= '0;
      k_d       <= '0;
      k_e       <= '0;
      k_f       <= '0;
      k_h       <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_base    <= '0;
      r_dst_idx <= '0;
    end else begin
      case (r_state)
        S_F1:   k_b <= src_data;
        S_F2:   k_d <= src_data;
        S_F3:   k_e <= src_data;
        S_F4:   k_f <= src_data;
        S_LAST: k_h <= src_data;
        S_DONE: begin
          r_row     <= '0;
          r_col     <= '0;
          r_base    <= '0;
          r_dst_idx <= '0;
        end
        default: ;
      endcase
      if (w_wr_done) begin
        r_dst_idx <= r_dst_idx + ADDR_W'(1);
        if (w_last_col) begin
          // Skip the two border columns to land on the next row's first pixel.
          r_col  <= '0;
          r_row  <= r_row + ADDR_W'(1);
          r_base <= r_base + ADDR_W'(3);
        end else begin
          r_col  <= r_col + ADDR_W'(1);
          r_base <= r_base + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_laplace_scheduler.sv
// Bench for laplace_scheduler on a 4x5 image: source memory model,
// behavioural kernel (4e-b-d-f-h, or a stub constant), and a scoreboard
// of expected read addresses and writes checked by a monitor process.
module tb_laplace_scheduler;
  localparam int ROWS = 4;
  localparam int COLS = 5;
  localparam int AW   = 18;
  localparam int NPIX = (ROWS - 2) * (COLS - 2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, src_rd, dst_we;
  logic [AW-1:0] src_addr, dst_addr;
  logic [7:0]    src_data = 8'd0;
  logic [7:0]    k_b, k_d, k_e, k_f, k_h, dst_data;
  logic [8:0]    k_s;
  logic          dst_ready = 1'b1;
  logic          stub = 1'b0;

  logic [7:0]    mem [ROWS*COLS];
  logic [AW-1:0] q_src [$];
  logic [AW-1:0] q_waddr [$];
  logic [7:0]    q_wdata [$];

  int n_chk = 0;
  int n_fail = 0;

  laplace_scheduler #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
    .k_b(k_b), .k_d(k_d), .k_e(k_e), .k_f(k_f), .k_h(k_h), .k_s(k_s),
    .dst_we(dst_we), .dst_addr(dst_addr), .dst_data(dst_data),
    .dst_ready(dst_ready)
  );

  always #5 clk = ~clk;

  // Source RAM: data valid one cycle after the read strobe.
  always @(posedge clk)
    if (src_rd && src_addr < AW'(ROWS*COLS)) src_data <= mem[src_addr];

  // Behavioural kernel, or a stub that exercises the ninth bit.
  always_comb begin
    if (stub) k_s = 9'h1A5;
    else      k_s = 9'(4 * int'(k_e) - int'(k_b) - int'(k_d) - int'(k_f) - int'(k_h));
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_px(input int r, input int c);
    int b, d, e, f, h;
    b = mem[r*COLS + c + 1];
    d = mem[(r+1)*COLS + c];
    e = mem[(r+1)*COLS + c + 1];
    f = mem[(r+1)*COLS + c + 2];
    h = mem[(r+2)*COLS + c + 1];
    return 8'(4*e - b - d - f - h);
  endfunction

  // Push expected reads for pixels [0,nsrc_pix) plus extra partial reads,
  // and expected writes for pixels [0,nwr).
  task automatic push_exp(input int nsrc_pix, input int extra, input int nwr);
    int base;
    for (int p = 0; p < nsrc_pix + (extra > 0 ? 1 : 0); p++) begin
      int offs [5];
      base = (p / (COLS-2)) * COLS + (p % (COLS-2));
      offs = '{1, COLS, COLS+1, COLS+2, 2*COLS+1};
      for (int i = 0; i < ((p < nsrc_pix) ? 5 : extra); i++)
        q_src.push_back(AW'(base + offs[i]));
    end
    for (int p = 0; p < nwr; p++) begin
      q_waddr.push_back(AW'(p));
      q_wdata.push_back(stub ? 8'hA5 : model_px(p / (COLS-2), p % (COLS-2)));
    end
  endtask

  // Monitor: compares reads/writes against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (src_rd) begin
        if (q_src.size() == 0) chk("unexpected src_rd", 1, 0);
        else chk("src_addr", int'(src_addr), int'(q_src.pop_front()));
      end
      if (dst_we) begin
        if (q_waddr.size() == 0) chk("unexpected dst_we", 1, 0);
        else if (dst_ready) begin
          chk("dst_addr", int'(dst_addr), int'(q_waddr.pop_front()));
          chk("dst_data", int'(dst_data), int'(q_wdata.pop_front()));
        end else begin
          chk("stall dst_addr", int'(dst_addr), int'(q_waddr[0]));
          chk("stall dst_data", int'(dst_data), int'(q_wdata[0]));
        end
      end
    end
  end

  task automatic check_zero(input string name);
    chk({name, " ctl"}, int'({busy, done, src_rd, dst_we}), 0);
    chk({name, " addr"}, int'(|{src_addr, dst_addr}), 0);
    chk({name, " data"}, int'(|{dst_data, k_b, k_d, k_e, k_f, k_h}), 0);
  endtask

  task automatic check_drained(input string name);
    chk({name, " src left"}, q_src.size(), 0);
    chk({name, " wr left"}, q_waddr.size(), 0);
    q_src.delete(); q_waddr.delete(); q_wdata.delete();
  endtask

  // One pass: accept start, count cycles to done, optional first-write stall.
  task automatic run_pass(input string name, input int exp_done, input int stall);
    int cnt;
    dst_ready = (stall == 0);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk); cnt++;
      if (cnt == 1) chk({name, " busy after accept"}, int'(busy), 1);
      if (stall > 0 && cnt == 7) chk({name, " we in stall"}, int'(dst_we), 1);
      if (stall > 0 && cnt == 6 + stall) begin
        @(posedge clk); #1 dst_ready = 1'b1;
      end
    end while (!done && cnt < 400);
    chk({name, " done cycle"}, cnt, exp_done);
    chk({name, " busy at done"}, int'(busy), 0);
    @(negedge clk);
    chk({name, " done pulse"}, int'(done), 0);
    check_drained(name);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < ROWS*COLS; i++) mem[i] = 8'd10;

    // Reset with start held: must be ignored.
    rst = 1'b1; start = 1'b1;
    @(negedge clk); check_zero("reset c1");
    @(negedge clk); check_zero("reset c2");
    rst = 1'b0; start = 1'b0;
    @(negedge clk); check_zero("post reset");
    @(negedge clk); chk("idle src_rd", int'(src_rd), 0);

    // Constant image, real kernel: all zero results, done at 43.
    push_exp(NPIX, 0, NPIX);
    run_pass("const", 1 + 7*NPIX, 0);

    // Non-constant image, real kernel.
    for (int i = 0; i < ROWS*COLS; i++) mem[i] = 8'(i*37 + 5);
    push_exp(NPIX, 0, NPIX);
    run_pass("ramp", 1 + 7*NPIX, 0);

    // Stub kernel: 9'h1A5 truncates to 8'hA5.
    stub = 1'b1;
    push_exp(NPIX, 0, NPIX);
    run_pass("stub", 1 + 7*NPIX, 0);
    stub = 1'b0;

    // Three-cycle stall at the first write.
    push_exp(NPIX, 0, NPIX);
    run_pass("stall", 1 + 7*NPIX + 3, 3);

    // Reset in F2 of pixel 4 (cycle 31): abort, then a clean restart.
    push_exp(4, 3, 4);
    dst_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = 0;
    while (cnt < 31) begin @(negedge clk); cnt++; end
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_zero("abort");
    check_drained("abort");
    repeat (3) @(negedge clk);
    chk("abort stays idle", int'(busy | src_rd | dst_we), 0);
    push_exp(NPIX, 0, NPIX);
    run_pass("restart", 1 + 7*NPIX, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
